mem_wb_stage: RTL and testbench

//  MEM/WB pipeline register and write-back stage, directly downstream of the MEM stage.

---
 rtl/pipeline_pkg.sv | 15 +
 rtl/mem_wb_stage_if.sv | 48 ++++
 rtl/mem_wb_stage_wb_mux.sv | 13 +
 rtl/mem_wb_stage.sv | 113 +++++++++++
 tb/tb_mem_wb_stage.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: write-back state encoding, the zero register index
// and the default datapath widths used by the MEM/WB slice.
package pipeline_pkg;

  localparam int DEFAULT_DATA_W     = 32;
  localparam int DEFAULT_REG_ADDR_W = 5;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic {
    WB_RUN    = 1'b0,
    WB_HALTED = 1'b1
  } wb_state_e;

endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM -> WB bundle plus the write-back outputs of the stage.
// Counter signals exist only when WB_STATS_EN is defined.
interface mem_wb_stage_if
  import pipeline_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W
`ifdef WB_STATS_EN
  , parameter int CNT_W    = 32
`endif
);

  logic [DATA_W-1:0]     i_m_wb_read_data;
  logic [DATA_W-1:0]     i_m_wb_alu_result;
  logic [REG_ADDR_W-1:0] i_m_wb_rd;
  logic                  i_m_wb_mem_to_reg;
  logic                  i_m_wb_reg_write;
  logic                  i_m_wb_halt;

  logic [DATA_W-1:0]     o_wb_write_data;
  logic [REG_ADDR_W-1:0] o_wb_rd;
  logic                  o_wb_reg_write;
  logic                  o_wb_halted;
`ifdef WB_STATS_EN
  logic [CNT_W-1:0]      o_wb_cycle_count;
  logic [CNT_W-1:0]      o_wb_retire_count;
`endif

  // The master is the MEM side feeding the stage; the slave is the stage itself.
  modport master (
    output i_m_wb_read_data, i_m_wb_alu_result, i_m_wb_rd,
    output i_m_wb_mem_to_reg, i_m_wb_reg_write, i_m_wb_halt,
    input  o_wb_write_data, o_wb_rd, o_wb_reg_write, o_wb_halted
`ifdef WB_STATS_EN
    , input o_wb_cycle_count, o_wb_retire_count
`endif
  );

  modport slave (
    input  i_m_wb_read_data, i_m_wb_alu_result, i_m_wb_rd,
    input  i_m_wb_mem_to_reg, i_m_wb_reg_write, i_m_wb_halt,
    output o_wb_write_data, o_wb_rd, o_wb_reg_write, o_wb_halted
`ifdef WB_STATS_EN
    , output o_wb_cycle_count, o_wb_retire_count
`endif
  );

endinterface

// File: rtl/mem_wb_stage_wb_mux.sv
// Combinational write-back data select, also instantiated by the forwarding unit.
module wb_mux #(
  parameter int DATA_W = 32
) (
  input  logic              sel_i,
  input  logic [DATA_W-1:0] load_data_i,
  input  logic [DATA_W-1:0] alu_result_i,
  output logic [DATA_W-1:0] data_o
);

  assign data_o = sel_i ? load_data_i : alu_result_i;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register, write-back select and halt-retire FSM.
// Define WB_STATS_EN to add the cycle and retire statistics counters.
module mem_wb_stage
  import pipeline_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W
`ifdef WB_STATS_EN
  , parameter int CNT_W    = 32
`endif
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_enable,
  mem_wb_stage_if.slave wb_if
);

  wb_state_e             state_q, state_d;
  logic [DATA_W-1:0]     read_data_q, read_data_d;
  logic [DATA_W-1:0]     alu_result_q, alu_result_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic                  mem_to_reg_q, mem_to_reg_d;
  logic                  reg_write_q, reg_write_d;
  logic                  halt_q, halt_d;
  logic                  latch_en;

  // Once halted the debug unit's enable is ignored, so the stage freezes.
  assign latch_en = i_enable && (state_q == WB_RUN);

  always_comb begin
    state_d      = state_q;
    read_data_d  = read_data_q;
    alu_result_d = alu_result_q;
    rd_d         = rd_q;
    mem_to_reg_d = mem_to_reg_q;
    reg_write_d  = reg_write_q;
    halt_d       = halt_q;
    if (latch_en) begin
      read_data_d  = wb_if.i_m_wb_read_data;
      alu_result_d = wb_if.i_m_wb_alu_result;
      rd_d         = wb_if.i_m_wb_rd;
      mem_to_reg_d = wb_if.i_m_wb_mem_to_reg;
      reg_write_d  = wb_if.i_m_wb_reg_write;
      halt_d       = wb_if.i_m_wb_halt;
      if (wb_if.i_m_wb_halt) begin
        state_d = WB_HALTED;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= WB_RUN;
      read_data_q  <= '0;
      alu_result_q <= '0;
      rd_q         <= '0;
      mem_to_reg_q <= 1'b0;
      reg_write_q  <= 1'b0;
      halt_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      read_data_q  <= read_data_d;
      alu_result_q <= alu_result_d;
      rd_q         <= rd_d;
      mem_to_reg_q <= mem_to_reg_d;
      reg_write_q  <= reg_write_d;
      halt_q       <= halt_d;
    end
  end

  wb_mux #(.DATA_W(DATA_W)) u_wb_mux (
    .sel_i        (mem_to_reg_q),
    .load_data_i  (read_data_q),
    .alu_result_i (alu_result_q),
    .data_o       (wb_if.o_wb_write_data)
  );

  // The halting instruction and anything targeting $0 never reach the register file.
  assign wb_if.o_wb_rd          = rd_q;
  assign wb_if.o_wb_reg_write   = reg_write_q && (rd_q != REG_ADDR_W'(REG_ZERO)) &&
                                  !halt_q && (state_q == WB_RUN);
  assign wb_if.o_wb_halted      = (state_q == WB_HALTED);

`ifdef WB_STATS_EN
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

  always_comb begin
    cycle_cnt_d  = cycle_cnt_q;
    retire_cnt_d = retire_cnt_q;
    if (latch_en) begin
      cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
      if ((wb_if.i_m_wb_reg_write || wb_if.i_m_wb_mem_to_reg) && !wb_if.i_m_wb_halt) begin
        retire_cnt_d = retire_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cycle_cnt_q  <= '0;
      retire_cnt_q <= '0;
    end else begin
      cycle_cnt_q  <= cycle_cnt_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign wb_if.o_wb_cycle_count  = cycle_cnt_q;
  assign wb_if.o_wb_retire_count = retire_cnt_q;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios plus randomized traffic
// compared against an instruction-level model; counter checks apply with WB_STATS_EN.
module tb_mem_wb_stage;

  localparam int DW = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic reset;
  logic enable;

  mem_wb_stage_if #(.DATA_W(DW), .REG_ADDR_W(AW)) bus ();

  mem_wb_stage #(.DATA_W(DW), .REG_ADDR_W(AW)) dut (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_enable (enable),
    .wb_if    (bus)
  );

  always #5 clk = ~clk;

  int testCount = 0;
  int failCount = 0;

  // Model: the last accepted instruction and whether the pipeline has drained.
  logic [31:0] mData   = '0;
  logic [4:0]  mRd     = '0;
  logic        mWe     = 1'b0;
  logic        mHalted = 1'b0;
`ifdef WB_STATS_EN
  logic [31:0] mCyc    = '0;
  logic [31:0] mRet    = '0;
`endif

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, " data"}, bus.o_wb_write_data, mData);
    checkVal({tag, " rd"}, 32'(bus.o_wb_rd), 32'(mRd));
    checkVal({tag, " we"}, 32'(bus.o_wb_reg_write), 32'(mWe && !mHalted));
    checkVal({tag, " halted"}, 32'(bus.o_wb_halted), 32'(mHalted));
`ifdef WB_STATS_EN
    checkVal({tag, " cycles"}, bus.o_wb_cycle_count, mCyc);
    checkVal({tag, " retired"}, bus.o_wb_retire_count, mRet);
`endif
  endtask

  task automatic modelClock(input logic rst, input logic en, input logic [31:0] rdata,
                            input logic [31:0] alu, input logic [4:0] rd,
                            input logic m2r, input logic rw, input logic halt);
    if (rst) begin
      mData = '0; mRd = '0; mWe = 1'b0; mHalted = 1'b0;
`ifdef WB_STATS_EN
      mCyc = '0; mRet = '0;
`endif
    end else if (en && !mHalted) begin
      mData   = m2r ? rdata : alu;
      mRd     = rd;
      mWe     = rw && (rd != 5'd0) && !halt;
      mHalted = halt;
`ifdef WB_STATS_EN
      mCyc = mCyc + 32'd1;
      if ((rw || m2r) && !halt) mRet = mRet + 32'd1;
`endif
    end
  endtask

  // Drive one MEM-stage cycle at the falling edge, clock it, check at the next falling edge.
  task automatic applyStimulus(input string tag, input logic rst, input logic en,
                               input logic [31:0] rdata, input logic [31:0] alu,
                               input logic [4:0] rd, input logic m2r, input logic rw,
                               input logic halt);
    reset                 = rst;
    enable                = en;
    bus.i_m_wb_read_data  = rdata;
    bus.i_m_wb_alu_result = alu;
    bus.i_m_wb_rd         = rd;
    bus.i_m_wb_mem_to_reg = m2r;
    bus.i_m_wb_reg_write  = rw;
    bus.i_m_wb_halt       = halt;
    @(posedge clk);
    modelClock(rst, en, rdata, alu, rd, m2r, rw, halt);
    @(negedge clk);
    checkOutput(tag);
  endtask

  task automatic randomCycle(input string tag, input int rstPct, input int haltPct);
    logic        rst, en, m2r, rw, halt;
    logic [4:0]  rd;
    rst  = ($urandom_range(0, 99) < rstPct);
    en   = ($urandom_range(0, 9) < 7);
    m2r  = 1'($urandom_range(0, 1));
    rw   = ($urandom_range(0, 3) != 0);
    halt = ($urandom_range(0, 99) < haltPct);
    rd   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    applyStimulus(tag, rst, en, $urandom, $urandom, rd, m2r, rw, halt);
  endtask

  initial begin
    #200000;
    $display("[TB] watchdog expired before the sequence completed");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    bus.i_m_wb_read_data = '0;
    bus.i_m_wb_alu_result = '0;
    bus.i_m_wb_rd = '0;
    bus.i_m_wb_mem_to_reg = 1'b0;
    bus.i_m_wb_reg_write = 1'b0;
    bus.i_m_wb_halt = 1'b0;
    @(negedge clk);

    applyStimulus("reset0", 1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("reset1", 1, 1, 32'hDEAD_BEEF, 32'h5555, 5'd9, 1, 1, 0);

    applyStimulus("alu_wb", 0, 1, 32'h0, 32'h0000_00AA, 5'd5, 0, 1, 0);
    checkVal("alu_wb const data", bus.o_wb_write_data, 32'h0000_00AA);
    checkVal("alu_wb const we", 32'(bus.o_wb_reg_write), 32'd1);

    applyStimulus("load_wb", 0, 1, 32'hFFFF_FF80, 32'h10, 5'd7, 1, 1, 0);
    checkVal("load_wb const data", bus.o_wb_write_data, 32'hFFFF_FF80);
    checkVal("load_wb const rd", 32'(bus.o_wb_rd), 32'd7);

    applyStimulus("rd_zero", 0, 1, 32'h0, 32'h1234, 5'd0, 0, 1, 0);
    checkVal("rd_zero const we", 32'(bus.o_wb_reg_write), 32'd0);
    checkVal("rd_zero const data", bus.o_wb_write_data, 32'h1234);

    for (int i = 0; i < 60; i++) randomCycle("rand_run", 0, 0);

    applyStimulus("halt", 0, 1, 32'h0, 32'h77, 5'd3, 0, 1, 1);
    checkVal("halt const halted", 32'(bus.o_wb_halted), 32'd1);
    checkVal("halt const we", 32'(bus.o_wb_reg_write), 32'd0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus("halt_frozen", 0, 1, $urandom, $urandom, 5'd4, 0, 1, 0);
      checkVal("halt_frozen const rd", 32'(bus.o_wb_rd), 32'd3);
    end
    applyStimulus("halt_reset", 1, 1, 32'h1, 32'h2, 5'd4, 0, 1, 0);
    checkVal("halt_reset const halted", 32'(bus.o_wb_halted), 32'd0);
    checkVal("halt_reset const data", bus.o_wb_write_data, 32'd0);

    for (int p = 0; p < 5; p++) begin
      applyStimulus("step_pulse", 0, 1, $urandom, $urandom, 5'(p + 1), 0, 1, 0);
      checkVal("step_pulse const rd", 32'(bus.o_wb_rd), 32'(p + 1));
      for (int k = 0; k < 3; k++) begin
        applyStimulus("step_hold", 0, 0, $urandom, $urandom, 5'(p + 10 + k), 1, 1, 0);
        checkVal("step_hold const rd", 32'(bus.o_wb_rd), 32'(p + 1));
      end
    end
`ifdef WB_STATS_EN
    checkVal("step const cycles", bus.o_wb_cycle_count, 32'd5);
    checkVal("step const retired", bus.o_wb_retire_count, 32'd5);
`endif

    for (int i = 0; i < 120; i++) randomCycle("rand_mix", 8, 6);

    applyStimulus("pre_rst_halt", 1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("pre_rst_halt", 0, 1, 32'h0, 32'h99, 5'd12, 0, 1, 0);
    applyStimulus("rst_halt", 1, 1, 32'h0, 32'h55, 5'd6, 0, 1, 1);
    checkVal("rst_halt const halted", 32'(bus.o_wb_halted), 32'd0);
    checkVal("rst_halt const data", bus.o_wb_write_data, 32'd0);
    applyStimulus("post_rst_halt", 0, 1, 32'h0, 32'h66, 5'd8, 0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
